// File: rtl/prediction_display.sv
// prediction_display: tracks one inference run from start to done, measures
// its latency in LAT_DIV-cycle ticks and drives six hex digits showing the
// latency count (HEX5..HEX1) and the predicted class (HEX0).
module prediction_display #(
  parameter int unsigned LAT_DIV = 50
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        done,
  input  logic [3:0]  digit,
  output logic [23:0] hex_nib,
  output logic [5:0]  hex_en,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_SHOW
  } state_t;

  localparam logic [15:0] PRE_MAX = 16'(LAT_DIV - 1);
  localparam logic [19:0] CNT_MAX = '1;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pre,   w_pre_nxt;
  logic [19:0] r_cnt,   w_cnt_nxt;
  logic [3:0]  r_dig,   w_dig_nxt;

  // State, prescaler, latency count and captured digit registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_cnt   <= '0;
      r_dig   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dig   <= w_dig_nxt;
    end
  end

  // Next-state logic: done beats start in BUSY; the count saturates, never wraps
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_cnt_nxt   = r_cnt;
    w_dig_nxt   = r_dig;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pre_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (done) begin
          w_dig_nxt   = digit;
          w_state_nxt = S_SHOW;
        end else if (start) begin
          w_pre_nxt = '0;
          w_cnt_nxt = '0;
        end else if (r_pre == PRE_MAX) begin
          w_pre_nxt = '0;
          if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 20'd1;
          end
        end else begin
          w_pre_nxt = r_pre + 16'd1;
        end
      end
      S_SHOW: begin
        if (start) begin
          w_pre_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    hex_nib = {r_cnt, r_dig};
    busy    = 1'b0;
    err     = 1'b0;
    hex_en  = '0;
    case (r_state)
      S_BUSY: begin
        busy   = 1'b1;
        hex_en = 6'b111110;
      end
      S_SHOW: begin
        hex_en = {5'b11111, (r_dig <= 4'd9)};
        err    = (r_dig > 4'd9);
      end
      default: begin
        hex_en = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_prediction_display.sv
// Directed bench for prediction_display with LAT_DIV=4.
module tb_prediction_display;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        done;
  logic [3:0]  digit;
  logic [23:0] hex_nib;
  logic [5:0]  hex_en;
  logic        busy;
  logic        err;

  int n_checks;
  int n_pass;

  prediction_display #(.LAT_DIV(4)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (start),
    .done    (done),
    .digit   (digit),
    .hex_nib (hex_nib),
    .hex_en  (hex_en),
    .busy    (busy),
    .err     (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Check all four outputs at once
  task automatic chk_all(input string tag, input logic [23:0] e_nib, input logic [5:0] e_en,
                         input logic e_busy, input logic e_err);
    chk({tag, ".hex_nib"}, 32'(hex_nib), 32'(e_nib));
    chk({tag, ".hex_en"},  32'(hex_en),  32'(e_en));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".err"},     32'(err),     32'(e_err));
  endtask

  // Apply inputs for exactly one rising edge, then sample #1 after it
  task automatic step(input logic s, input logic d, input logic [3:0] dg);
    start = s;
    done  = d;
    digit = dg;
    @(posedge Clk);
    #1;
    start = 1'b0;
    done  = 1'b0;
    digit = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset = 1'b1;
    start = 1'b0;
    done  = 1'b0;
    digit = 4'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk_all("reset", 24'h000000, 6'b000000, 1'b0, 1'b0);
    Reset = 1'b0;

    // Stray done in IDLE is ignored
    step(1'b0, 1'b1, 4'd5);
    chk_all("idle_done", 24'h000000, 6'b000000, 1'b0, 1'b0);

    // Basic run: start at edge 0, done digit 7 at edge 10 -> cnt 2
    step(1'b1, 1'b0, 4'd0);
    chk_all("basic_start", 24'h000000, 6'b111110, 1'b1, 1'b0);
    idle(9);
    chk("basic_live", 32'(hex_nib), 32'h000020);
    step(1'b0, 1'b1, 4'd7);
    chk_all("basic_show", 24'h000027, 6'b111111, 1'b0, 1'b0);

    // Second done in SHOW changes nothing
    step(1'b0, 1'b1, 4'd1);
    chk_all("show_done", 24'h000027, 6'b111111, 1'b0, 1'b0);

    // Restart: start at edge 0, restart at edge 5, done digit 3 at edge 14
    step(1'b1, 1'b0, 4'd0);
    idle(4);
    chk("restart_pre", 32'(hex_nib), 32'h000017);
    step(1'b1, 1'b0, 4'd0);
    chk_all("restart_mid", 24'h000007, 6'b111110, 1'b1, 1'b0);
    idle(8);
    step(1'b0, 1'b1, 4'd3);
    chk_all("restart_show", 24'h000023, 6'b111111, 1'b0, 1'b0);

    // Illegal digit shows as a dash and raises err
    step(1'b1, 1'b0, 4'd0);
    idle(2);
    step(1'b0, 1'b1, 4'hC);
    chk_all("illegal", 24'h00000C, 6'b111110, 1'b0, 1'b1);

    // Simultaneous start and done in BUSY: done wins
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd9);
    chk_all("simul", 24'h000009, 6'b111111, 1'b0, 1'b0);

    // Saturation: preset count near the top, then let it run
    step(1'b1, 1'b0, 4'd0);
    force dut.r_cnt = 20'hFFFFE;
    @(posedge Clk);
    #1;
    release dut.r_cnt;
    idle(12);
    chk("sat_live", 32'(hex_nib[23:4]), 32'h0FFFFF);
    chk("sat_busy", 32'(busy), 32'h1);
    step(1'b0, 1'b1, 4'd4);
    chk_all("sat_show", 24'hFFFFF4, 6'b111111, 1'b0, 1'b0);

    // Async reset mid-BUSY takes effect before the next edge
    step(1'b1, 1'b0, 4'd0);
    idle(5);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    Reset = 1'b1;
    #1;
    chk_all("async_rst", 24'h000000, 6'b000000, 1'b0, 1'b0);

    // Inputs ignored while reset is held
    @(negedge Clk);
    start = 1'b1;
    done  = 1'b1;
    digit = 4'd6;
    @(posedge Clk);
    #1;
    chk_all("rst_hold", 24'h000000, 6'b000000, 1'b0, 1'b0);
    start = 1'b0;
    done  = 1'b0;
    digit = 4'd0;
    @(negedge Clk);
    Reset = 1'b0;

    // First edge after release samples normally
    step(1'b1, 1'b0, 4'd0);
    chk_all("post_rst", 24'h000000, 6'b111110, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
